i2s_receiver: RTL and testbench

I2S slave receiver for the audio input path, the capture counterpart of the DAC-side I2S transmitter. It oversamples externally driven bit clock, word clock and serial data on the system audio clock, deserialises standard-I2S frames (MSB first, one bit-clock delay after the word-clock edge) and presents one signed left/right sample pair per frame with a single-cycle valid strobe. It sits between the ADC pins and the synth/FFT input stage.

---
 rtl/i2s_receiver_if.sv | 36 +++
 rtl/i2s_receiver.sv | 183 ++++++++++++++++++
 tb/tb_i2s_receiver.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_receiver_if.sv
// I2S receiver port bundle: ADC pins plus the captured-sample outputs.
// The audio_mono member exists only when I2S_RX_MONO_EN is defined.
interface i2s_receiver_if #(
    parameter int AUDIO_BIT_WIDTH = 24
);
    logic                       i2s_bit_clock;
    logic                       i2s_left_right_clock;
    logic                       i2s_data;
    logic [AUDIO_BIT_WIDTH-1:0] audio_left;
    logic [AUDIO_BIT_WIDTH-1:0] audio_right;
    logic                       audio_valid;
    logic                       frame_error;
`ifdef I2S_RX_MONO_EN
    logic [AUDIO_BIT_WIDTH-1:0] audio_mono;
`endif

`ifdef I2S_RX_MONO_EN
    modport master (
        output i2s_bit_clock, i2s_left_right_clock, i2s_data,
        input  audio_left, audio_right, audio_valid, frame_error, audio_mono
    );
    modport slave (
        input  i2s_bit_clock, i2s_left_right_clock, i2s_data,
        output audio_left, audio_right, audio_valid, frame_error, audio_mono
    );
`else
    modport master (
        output i2s_bit_clock, i2s_left_right_clock, i2s_data,
        input  audio_left, audio_right, audio_valid, frame_error
    );
    modport slave (
        input  i2s_bit_clock, i2s_left_right_clock, i2s_data,
        output audio_left, audio_right, audio_valid, frame_error
    );
`endif
endinterface

// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples the ADC bit clock, word clock and data and
// deserialises standard I2S frames into signed left/right pairs. Optional mono mix: I2S_RX_MONO_EN.
module i2s_receiver #(
    parameter int AUDIO_BIT_WIDTH = 24
) (
    input  logic          clock_16_934_400,
    input  logic          reset,
    i2s_receiver_if.slave i2s
);
    localparam int COUNT_WIDTH = $clog2(AUDIO_BIT_WIDTH);

    typedef enum logic [1:0] {SYNC, SKIP, SHIFT, WAIT} state_t;

    state_t                     state;
    state_t                     state_next;
    logic [1:0]                 bit_clock_sync;
    logic [1:0]                 left_right_sync;
    logic [1:0]                 data_sync;
    logic                       bit_clock_prev;
    logic                       left_right_prev;
    logic                       sample_strobe;
    logic                       left_right_now;
    logic                       data_now;
    logic                       word_edge;
    logic [COUNT_WIDTH-1:0]     bit_count;
    logic [AUDIO_BIT_WIDTH-2:0] shift_reg;
    logic [AUDIO_BIT_WIDTH-1:0] captured_word;
    logic [AUDIO_BIT_WIDTH-1:0] left_hold;
    logic [AUDIO_BIT_WIDTH-1:0] audio_left_reg;
    logic [AUDIO_BIT_WIDTH-1:0] audio_right_reg;
    logic                       audio_valid_reg;
    logic                       frame_error_reg;
    logic                       channel;
    logic                       left_captured;
    logic                       shift_first;
    logic                       shift_next;
    logic                       word_done;
    logic                       word_abort;
    logic                       pair_ready;

    // Word clock is only compared at bit-clock rising edges, so its previous value lives here too
    always_ff @(posedge clock_16_934_400 or posedge reset) begin
        if (reset) begin
            bit_clock_sync  <= '0;
            left_right_sync <= '0;
            data_sync       <= '0;
            bit_clock_prev  <= 1'b0;
            left_right_prev <= 1'b0;
        end else begin
            bit_clock_sync  <= {bit_clock_sync[0], i2s.i2s_bit_clock};
            left_right_sync <= {left_right_sync[0], i2s.i2s_left_right_clock};
            data_sync       <= {data_sync[0], i2s.i2s_data};
            bit_clock_prev  <= bit_clock_sync[1];
            if (sample_strobe) begin
                left_right_prev <= left_right_sync[1];
            end
        end
    end

    assign sample_strobe  = bit_clock_sync[1] & ~bit_clock_prev;
    assign left_right_now = left_right_sync[1];
    assign data_now       = data_sync[1];
    assign word_edge      = left_right_now != left_right_prev;
    assign captured_word  = {shift_reg, data_now};
    assign pair_ready     = word_done & channel & left_captured;

    always_ff @(posedge clock_16_934_400 or posedge reset) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // The strobe leaving SKIP already carries the MSB; a slot exactly one word wide
    // delivers its LSB together with the next word-clock edge, which is not an error.
    always_comb begin
        state_next  = state;
        shift_first = 1'b0;
        shift_next  = 1'b0;
        word_done   = 1'b0;
        word_abort  = 1'b0;
        if (sample_strobe) begin
            unique case (state)
                SYNC: begin
                    if (word_edge && !left_right_now) begin
                        state_next = SKIP;
                    end
                end
                SKIP: begin
                    if (word_edge) begin
                        word_abort = 1'b1;
                        state_next = SYNC;
                    end else begin
                        shift_first = 1'b1;
                        state_next  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_count == '0) begin
                        word_done  = 1'b1;
                        state_next = word_edge ? SKIP : WAIT;
                    end else if (word_edge) begin
                        word_abort = 1'b1;
                        state_next = SYNC;
                    end else begin
                        shift_next = 1'b1;
                    end
                end
                WAIT: begin
                    if (word_edge) begin
                        state_next = SKIP;
                    end
                end
                default: state_next = SYNC;
            endcase
        end
    end

    // A left word only pairs with the right word that follows it in the same frame
    always_ff @(posedge clock_16_934_400 or posedge reset) begin
        if (reset) begin
            bit_count       <= '0;
            shift_reg       <= '0;
            channel         <= 1'b0;
            left_hold       <= '0;
            left_captured   <= 1'b0;
            audio_left_reg  <= '0;
            audio_right_reg <= '0;
            audio_valid_reg <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            audio_valid_reg <= 1'b0;
            frame_error_reg <= 1'b0;
            if (shift_first) begin
                shift_reg <= {shift_reg[AUDIO_BIT_WIDTH-3:0], data_now};
                bit_count <= COUNT_WIDTH'(AUDIO_BIT_WIDTH - 2);
                channel   <= left_right_now;
            end else if (shift_next) begin
                shift_reg <= {shift_reg[AUDIO_BIT_WIDTH-3:0], data_now};
                bit_count <= bit_count - COUNT_WIDTH'(1);
            end
            if (word_done && !channel) begin
                left_hold     <= captured_word;
                left_captured <= 1'b1;
            end
            if (pair_ready) begin
                audio_left_reg  <= left_hold;
                audio_right_reg <= captured_word;
                audio_valid_reg <= 1'b1;
                left_captured   <= 1'b0;
            end
            if (word_abort) begin
                frame_error_reg <= 1'b1;
                left_captured   <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_MONO_EN
    logic [AUDIO_BIT_WIDTH:0]   mono_sum;
    logic [AUDIO_BIT_WIDTH-1:0] audio_mono_reg;

    // One extra sum bit keeps the sign, so halving can never overflow
    assign mono_sum = {left_hold[AUDIO_BIT_WIDTH-1], left_hold}
                    + {captured_word[AUDIO_BIT_WIDTH-1], captured_word};

    always_ff @(posedge clock_16_934_400 or posedge reset) begin
        if (reset) begin
            audio_mono_reg <= '0;
        end else if (pair_ready) begin
            audio_mono_reg <= AUDIO_BIT_WIDTH'(mono_sum >> 1);
        end
    end

    assign i2s.audio_mono = audio_mono_reg;
`endif

    assign i2s.audio_left  = audio_left_reg;
    assign i2s.audio_right = audio_right_reg;
    assign i2s.audio_valid = audio_valid_reg;
    assign i2s.frame_error = frame_error_reg;
endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: drives I2S frames as an ADC would and
// scores every audio_valid pair against a queue of expected pairs.
module tb_i2s_receiver;
    localparam int W = 24;

    typedef struct {
        logic [W-1:0] left;
        logic [W-1:0] right;
        int           slot_bits;
        bit           expect_valid;
        logic [W-1:0] expect_mono;
    } frame_vector_t;

    typedef struct {
        logic [W-1:0] left;
        logic [W-1:0] right;
        logic [W-1:0] mono;
    } expected_pair_t;

    logic           clock_16_934_400 = 1'b0;
    logic           reset = 1'b1;
    logic           delayed_bit = 1'b0;
    logic           error_prev = 1'b0;
    int             tests_run = 0;
    int             tests_failed = 0;
    int             error_pulses = 0;
    expected_pair_t expected_queue[$];
    expected_pair_t front;
    frame_vector_t  vectors[8];

    always #5 clock_16_934_400 = ~clock_16_934_400;

    i2s_receiver_if #(.AUDIO_BIT_WIDTH(W)) bus ();

    i2s_receiver #(.AUDIO_BIT_WIDTH(W)) dut (
        .clock_16_934_400(clock_16_934_400),
        .reset(reset),
        .i2s(bus)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard side: every valid pulse must match the oldest queued pair
    always @(negedge clock_16_934_400) begin
        if (!reset) begin
            if (bus.audio_valid) begin
                if (expected_queue.size() == 0) begin
                    check_output("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    front = expected_queue.pop_front();
                    check_output("pair_left", 32'(bus.audio_left), 32'(front.left));
                    check_output("pair_right", 32'(bus.audio_right), 32'(front.right));
`ifdef I2S_RX_MONO_EN
                    check_output("pair_mono", 32'(bus.audio_mono), 32'(front.mono));
`endif
                end
            end
            if (bus.frame_error) begin
                error_pulses++;
                check_output("error_width", 32'(error_prev), 32'd0);
                check_output("valid_error_overlap", 32'(bus.audio_valid), 32'd0);
            end
        end
        error_prev = bus.frame_error;
    end

    task automatic wait_clocks(input int n);
        repeat (n) @(posedge clock_16_934_400);
        #1;
    endtask

    // Transmitter changes on the bit-clock fall; the data stream runs one bit behind the word clock
    task automatic send_bit(input logic lr, input logic value);
        bus.i2s_bit_clock        = 1'b0;
        bus.i2s_left_right_clock = lr;
        bus.i2s_data             = delayed_bit;
        delayed_bit              = value;
        wait_clocks(4);
        bus.i2s_bit_clock = 1'b1;
        wait_clocks(4);
    endtask

    task automatic send_slot(input logic lr, input logic [W-1:0] word, input int slot_bits);
        for (int k = 0; k < slot_bits; k++) begin
            send_bit(lr, (k < W) ? word[W-1-k] : 1'b0);
        end
    endtask

    task automatic apply_stimulus(input frame_vector_t v);
        expected_pair_t e;
        if (v.expect_valid) begin
            e.left  = v.left;
            e.right = v.right;
            e.mono  = v.expect_mono;
            expected_queue.push_back(e);
        end
        send_slot(1'b0, v.left, v.slot_bits);
        send_slot(1'b1, v.right, v.slot_bits);
    endtask

    function automatic frame_vector_t make_vector(input logic [W-1:0] l, input logic [W-1:0] r,
                                                  input int slots, input bit valid, input logic [W-1:0] mono);
        frame_vector_t v;
        v.left = l;
        v.right = r;
        v.slot_bits = slots;
        v.expect_valid = valid;
        v.expect_mono = mono;
        return v;
    endfunction

    task automatic flush_and_check(input string tag);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        wait_clocks(8);
        check_output({tag, "_pending_pairs"}, 32'(expected_queue.size()), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check_output({tag, "_left"}, 32'(bus.audio_left), 32'd0);
        check_output({tag, "_right"}, 32'(bus.audio_right), 32'd0);
        check_output({tag, "_valid"}, 32'(bus.audio_valid), 32'd0);
        check_output({tag, "_error"}, 32'(bus.frame_error), 32'd0);
`ifdef I2S_RX_MONO_EN
        check_output({tag, "_mono"}, 32'(bus.audio_mono), 32'd0);
`endif
    endtask

    task automatic reset_dut();
        reset                    = 1'b1;
        bus.i2s_bit_clock        = 1'b0;
        bus.i2s_left_right_clock = 1'b0;
        bus.i2s_data             = 1'b0;
        delayed_bit              = 1'b0;
        wait_clocks(1);
        check_cleared("reset");
        wait_clocks(3);
        expected_queue.delete();
        error_pulses = 0;
        reset = 1'b0;
        wait_clocks(4);
    endtask

    initial begin
        bus.i2s_bit_clock        = 1'b0;
        bus.i2s_left_right_clock = 1'b0;
        bus.i2s_data             = 1'b0;

        // Nominal and exact-width frames; the first frame only primes the word-clock edge
        vectors[0] = make_vector(24'h000000, 24'h000000, 32, 1'b0, 24'h000000);
        vectors[1] = make_vector(24'h123456, 24'hABCDEF, 32, 1'b1, 24'hDF0122);
        vectors[2] = make_vector(24'h123456, 24'hABCDEF, 32, 1'b1, 24'hDF0122);
        vectors[3] = make_vector(24'h7FFFFF, 24'h7FFFFF, 32, 1'b1, 24'h7FFFFF);
        vectors[4] = make_vector(24'h800000, 24'h000001, 32, 1'b1, 24'hC00000);
        vectors[5] = make_vector(24'h800000, 24'h7FFFFF, 24, 1'b1, 24'hFFFFFF);
        vectors[6] = make_vector(24'hFFFFFF, 24'h000000, 24, 1'b1, 24'hFFFFFF);
        vectors[7] = make_vector(24'h5A5A5A, 24'hA5A5A5, 32, 1'b1, 24'hFFFFFF);

        reset_dut();
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vectors[i]);
        end
        flush_and_check("nominal");
        check_output("nominal_errors", 32'(error_pulses), 32'd0);

        // Reset released in the middle of a right slot
        reset = 1'b1;
        expected_queue.delete();
        error_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            send_bit(1'b1, 1'($urandom_range(1)));
        end
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            send_bit(1'b1, 1'($urandom_range(1)));
        end
        apply_stimulus(make_vector(24'h13579B, 24'h2468AC, 32, 1'b1, 24'h1BE023));
        apply_stimulus(make_vector(24'h7FFFFF, 24'h7FFFFF, 32, 1'b1, 24'h7FFFFF));
        flush_and_check("midframe");
        check_output("midframe_errors", 32'(error_pulses), 32'd0);

        // Short left slot aborts the frame and leaves the outputs alone
        reset_dut();
        apply_stimulus(vectors[0]);
        apply_stimulus(vectors[1]);
        send_slot(1'b0, 24'h999999, 16);
        send_slot(1'b1, 24'h888888, 32);
        wait_clocks(8);
        check_output("short_errors", 32'(error_pulses), 32'd1);
        check_output("short_hold_left", 32'(bus.audio_left), 32'h123456);
        check_output("short_hold_right", 32'(bus.audio_right), 32'hABCDEF);
        apply_stimulus(make_vector(24'h0F0F0F, 24'hF0F0F0, 32, 1'b1, 24'hFFFFFF));
        flush_and_check("short");
        check_output("short_errors_after", 32'(error_pulses), 32'd1);

        // Reset ten bits into a left word clears everything on the next cycle
        reset_dut();
        apply_stimulus(vectors[0]);
        apply_stimulus(vectors[1]);
        wait_clocks(8);
        check_output("pre_reset_left", 32'(bus.audio_left), 32'h123456);
        check_output("pre_reset_queue", 32'(expected_queue.size()), 32'd0);
        for (int k = 0; k < 11; k++) begin
            send_bit(1'b0, (k < 10) ? 1'b1 : 1'b0);
        end
        reset = 1'b1;
        wait_clocks(1);
        check_cleared("midshift");
        reset_dut();
        apply_stimulus(vectors[0]);
        apply_stimulus(vectors[2]);
        flush_and_check("recovery");
        check_output("recovery_errors", 32'(error_pulses), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
